// File: rtl/bti_arb_if.sv
// BTI request and response channels shared by hosts, arbiter and guest.
// Valid/ready handshake; the sender holds vld and payload stable until rdy.
interface bti_req_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TW = 8
);
    logic          vld;
    logic          rdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic [TW-1:0] tid;

    modport mst (output vld, addr, data, we, tid, input rdy);
    modport slv (input vld, addr, data, we, tid, output rdy);
endinterface

interface bti_rsp_if #(
    parameter int DW = 32,
    parameter int TW = 8
);
    logic          vld;
    logic          rdy;
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic          ok;

    modport mst (output vld, tid, data, ok, input rdy);
    modport slv (input vld, tid, data, ok, output rdy);
endinterface

// File: rtl/bti_arb.sv
// Round-robin arbiter: HOST_NUM BTI hosts share one guest port, one transaction in flight.
// Latency: 1-cycle arbitration, then request/response are pass-through; ready flows straight between granted host and guest.
module bti_arb #(
    parameter int BTI_AW   = 32,
    parameter int BTI_DW   = 32,
    parameter int BTI_TW   = 8,
    parameter int HOST_NUM = 4,
    parameter int TMO_CYC  = 0
) (
    input  logic   clk,
    input  logic   rst,
    bti_req_if.slv host_bti_req_slvs [HOST_NUM],
    bti_rsp_if.mst host_bti_rsp_msts [HOST_NUM],
    bti_req_if.mst gst_bti_req_mst,
    bti_rsp_if.slv gst_bti_rsp_slv
);
    localparam int IW = $clog2(HOST_NUM);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_ERR} state_t;

    state_t              r_state, w_nxt_state;
    logic [IW-1:0]       r_gnt, r_rr_ptr, w_arb_idx, w_gnt_inc;
    logic [15:0]         r_tmo_cnt;
    logic [BTI_TW-1:0]   r_tid;
    logic                w_arb_found, w_req_hsk, w_rsp_hsk, w_err_hsk, w_tmo_hit;

    logic [HOST_NUM-1:0] w_h_vld, w_h_rdy, w_h_we, w_hr_vld, w_hr_rdy, w_hr_ok;
    logic [BTI_AW-1:0]   w_h_addr  [HOST_NUM];
    logic [BTI_DW-1:0]   w_h_data  [HOST_NUM];
    logic [BTI_TW-1:0]   w_h_tid   [HOST_NUM];
    logic [BTI_TW-1:0]   w_hr_tid  [HOST_NUM];
    logic [BTI_DW-1:0]   w_hr_data [HOST_NUM];

    logic                w_g_req_vld, w_g_req_we, w_g_rsp_rdy;
    logic [BTI_AW-1:0]   w_g_req_addr;
    logic [BTI_DW-1:0]   w_g_req_data;
    logic [BTI_TW-1:0]   w_g_req_tid;

    for (genvar i = 0; i < HOST_NUM; i++) begin : g_host
        assign w_h_vld[i]  = host_bti_req_slvs[i].vld;
        assign w_h_addr[i] = host_bti_req_slvs[i].addr;
        assign w_h_data[i] = host_bti_req_slvs[i].data;
        assign w_h_we[i]   = host_bti_req_slvs[i].we;
        assign w_h_tid[i]  = host_bti_req_slvs[i].tid;
        assign host_bti_req_slvs[i].rdy = w_h_rdy[i];

        assign host_bti_rsp_msts[i].vld  = w_hr_vld[i];
        assign host_bti_rsp_msts[i].tid  = w_hr_tid[i];
        assign host_bti_rsp_msts[i].data = w_hr_data[i];
        assign host_bti_rsp_msts[i].ok   = w_hr_ok[i];
        assign w_hr_rdy[i] = host_bti_rsp_msts[i].rdy;
    end

    assign gst_bti_req_mst.vld  = w_g_req_vld;
    assign gst_bti_req_mst.addr = w_g_req_addr;
    assign gst_bti_req_mst.data = w_g_req_data;
    assign gst_bti_req_mst.we   = w_g_req_we;
    assign gst_bti_req_mst.tid  = w_g_req_tid;
    assign gst_bti_rsp_slv.rdy  = w_g_rsp_rdy;

    // Scan order starts at r_rr_ptr and wraps explicitly, so non-power-of-2 HOST_NUM works.
    always_comb begin : arb_scan
        int j;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        j           = 0;
        for (int k = 0; k < HOST_NUM; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= HOST_NUM) j = j - HOST_NUM;
            if (!w_arb_found && w_h_vld[j]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IW'(j);
            end
        end
    end

    assign w_gnt_inc = (r_gnt == IW'(HOST_NUM - 1)) ? '0 : r_gnt + 1'b1;
    assign w_req_hsk = (r_state == S_REQ) && w_h_vld[r_gnt] && gst_bti_req_mst.rdy;
    assign w_rsp_hsk = (r_state == S_RSP) && gst_bti_rsp_slv.vld && w_hr_rdy[r_gnt];
    assign w_err_hsk = (r_state == S_ERR) && w_hr_rdy[r_gnt];
    assign w_tmo_hit = (TMO_CYC != 0) && (r_tmo_cnt == 16'(TMO_CYC - 1)) && !gst_bti_rsp_slv.vld;

    always_comb begin
        w_nxt_state  = r_state;
        w_h_rdy      = '0;
        w_hr_vld     = '0;
        w_hr_ok      = '0;
        for (int i = 0; i < HOST_NUM; i++) begin
            w_hr_tid[i]  = '0;
            w_hr_data[i] = '0;
        end
        w_g_req_vld  = 1'b0;
        w_g_req_addr = '0;
        w_g_req_data = '0;
        w_g_req_we   = 1'b0;
        w_g_req_tid  = '0;
        w_g_rsp_rdy  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Stale guest responses (after a timeout) are swallowed here.
                w_g_rsp_rdy = 1'b1;
                if (w_arb_found) w_nxt_state = S_REQ;
            end
            S_REQ: begin
                w_g_req_vld      = w_h_vld[r_gnt];
                w_g_req_addr     = w_h_addr[r_gnt];
                w_g_req_data     = w_h_data[r_gnt];
                w_g_req_we       = w_h_we[r_gnt];
                w_g_req_tid      = w_h_tid[r_gnt];
                w_h_rdy[r_gnt]   = gst_bti_req_mst.rdy;
                if (w_req_hsk)             w_nxt_state = S_RSP;
                else if (!w_h_vld[r_gnt])  w_nxt_state = S_IDLE;
            end
            S_RSP: begin
                w_hr_vld[r_gnt]  = gst_bti_rsp_slv.vld;
                w_hr_tid[r_gnt]  = gst_bti_rsp_slv.tid;
                w_hr_data[r_gnt] = gst_bti_rsp_slv.data;
                w_hr_ok[r_gnt]   = gst_bti_rsp_slv.ok;
                w_g_rsp_rdy      = w_hr_rdy[r_gnt];
                if (w_rsp_hsk)       w_nxt_state = S_IDLE;
                else if (w_tmo_hit)  w_nxt_state = S_ERR;
            end
            S_ERR: begin
                w_hr_vld[r_gnt]  = 1'b1;
                w_hr_tid[r_gnt]  = r_tid;
                if (w_err_hsk) w_nxt_state = S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_rr_ptr  <= '0;
            r_tmo_cnt <= '0;
            r_tid     <= '0;
        end else begin
            r_state <= w_nxt_state;
            if (r_state == S_IDLE && w_arb_found) r_gnt <= w_arb_idx;
            if (w_req_hsk) begin
                r_tid     <= w_h_tid[r_gnt];
                r_tmo_cnt <= '0;
            end
            if (r_state == S_RSP && !gst_bti_rsp_slv.vld) r_tmo_cnt <= r_tmo_cnt + 16'd1;
            if (w_rsp_hsk || w_err_hsk) r_rr_ptr <= w_gnt_inc;
        end
    end
endmodule
